// File: rtl/tm1638_pkg.sv
// Shared constants, state/command encodings and the 7-segment glyph table
// for the TM1638 front-panel frame sequencer.
package tm1638_pkg;

  localparam logic [7:0] CMD_DATA_WR = 8'h40;
  localparam logic [7:0] CMD_ADDR0   = 8'hC0;
  localparam logic [7:0] CMD_DISP    = 8'h80;
  localparam logic [7:0] GLYPH_BLANK = 8'h00;

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TAIL} state_t;
  typedef enum logic [1:0] {C0, C1, C2} cmd_t;

  // Index 15 (code F) is the blanking code used for unused digits.
  localparam logic [15:0][7:0] GLYPH = {
    GLYPH_BLANK, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
    8'h07,       8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

  typedef struct packed {
    logic [31:0] digits;
    logic [7:0]  dp;
    logic [7:0]  led;
    logic [2:0]  bright;
    logic        disp_on;
  } snap_t;

  // Display RAM byte for address 0..15: even = digit glyph + DP, odd = LED.
  function automatic logic [7:0] panel_byte(input snap_t s, input logic [3:0] addr);
    logic [2:0] k;
    k = addr[3:1];
    if (addr[0]) return {7'b0, s.led[k]};
    return GLYPH[s.digits[{k, 2'b00} +: 4]] | {s.dp[k], 7'b0};
  endfunction

endpackage

// File: rtl/tm1638_byte_tx.sv
// Serialises one byte LSB-first on the TM1638 CLK/DIO pair; each half-period
// lasts one divider period, and a load on the final tick chains bytes seamlessly.
module tm1638_byte_tx (
  input  logic       gclk,
  input  logic       grst_n,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] din,
  output logic       byte_last,
  output logic       tm_clk,
  output logic       tm_dio
);

  logic       active;
  logic       high;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;

  // Current bit sits in shreg[0]; ones shift in so DIO idles high after a byte.
  assign tm_dio    = shreg[0];
  assign byte_last = active && high && tick && (bit_cnt == 3'd7);

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      active  <= 1'b0;
      high    <= 1'b0;
      bit_cnt <= 3'd0;
      shreg   <= 8'hFF;
      tm_clk  <= 1'b1;
    end else if (load) begin
      active  <= 1'b1;
      high    <= 1'b0;
      bit_cnt <= 3'd0;
      shreg   <= din;
      tm_clk  <= 1'b0;
    end else if (active && tick) begin
      if (!high) begin
        high   <= 1'b1;
        tm_clk <= 1'b1;
      end else if (bit_cnt == 3'd7) begin
        active <= 1'b0;
        high   <= 1'b0;
        shreg  <= 8'hFF;
      end else begin
        high    <= 1'b0;
        bit_cnt <= bit_cnt + 3'd1;
        shreg   <= {1'b1, shreg[7:1]};
        tm_clk  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tm1638_frame_seq.sv
// TM1638 refresh-frame sequencer: snapshots the panel inputs on START and emits
// data-write, address+16 data bytes, and display-control commands.
module tm1638_frame_seq
  import tm1638_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [31:0] DIGITS,
  input  logic [7:0]  DP,
  input  logic [7:0]  LED,
  input  logic [2:0]  BRIGHT,
  input  logic        DISP_ON,
  output logic        BUSY,
  output logic        DONE,
  output logic        TM_CLK,
  output logic        TM_STB,
  output logic        TM_DIO
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_t           state;
  cmd_t             cmd;
  snap_t            snap;
  logic [4:0]       byte_idx;
  logic [4:0]       nxt_idx;
  logic [DIV_W-1:0] div;
  logic             tick;
  logic             more;
  logic             load;
  logic             byte_last;
  logic [7:0]       tx_byte;

  // One free-running divider paces LEAD/TAIL and every CLK half-period alike.
  assign tick = (div == DIV_W'(CLK_DIV - 1));
  assign more = (cmd == C1) && (byte_idx != 5'd16);
  assign load = (state == LEAD && tick) || (state == SHIFT && byte_last && more);

  always_comb begin
    nxt_idx = (state == LEAD) ? 5'd0 : byte_idx + 5'd1;
    tx_byte = CMD_DATA_WR;
    case (cmd)
      C0:      tx_byte = CMD_DATA_WR;
      C1:      tx_byte = (nxt_idx == 5'd0) ? CMD_ADDR0 : panel_byte(snap, 4'(nxt_idx - 5'd1));
      C2:      tx_byte = CMD_DISP | {4'b0, snap.disp_on, snap.bright};
      default: tx_byte = CMD_DATA_WR;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      cmd      <= C0;
      snap     <= '0;
      byte_idx <= 5'd0;
      div      <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      TM_STB   <= 1'b1;
    end else begin
      DONE <= 1'b0;
      div  <= (state == IDLE || tick) ? '0 : div + 1'b1;
      case (state)
        IDLE: if (START) begin
          state  <= LEAD;
          cmd    <= C0;
          snap   <= '{digits: DIGITS, dp: DP, led: LED, bright: BRIGHT, disp_on: DISP_ON};
          BUSY   <= 1'b1;
          TM_STB <= 1'b0;
        end
        LEAD: if (tick) begin
          state    <= SHIFT;
          byte_idx <= 5'd0;
        end
        SHIFT: if (byte_last) begin
          if (more) begin
            byte_idx <= byte_idx + 5'd1;
          end else begin
            state  <= TAIL;
            TM_STB <= 1'b1;
          end
        end
        TAIL: if (tick) begin
          if (cmd == C2) begin
            state <= IDLE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end else begin
            state  <= LEAD;
            cmd    <= (cmd == C0) ? C1 : C2;
            TM_STB <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  tm1638_byte_tx u_tx (
    .gclk      (CLK),
    .grst_n    (RST),
    .tick      (tick),
    .load      (load),
    .din       (tx_byte),
    .byte_last (byte_last),
    .tm_clk    (TM_CLK),
    .tm_dio    (TM_DIO)
  );

endmodule

// File: tb/tb_tm1638_frame_seq.sv
// Randomised bench for tm1638_frame_seq: a bus monitor decodes STB windows and
// compares them with frames built from the panel rules at D=2.
module tb_tm1638_frame_seq;

  localparam int D = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        START = 1'b0;
  logic [31:0] DIGITS = '0;
  logic [7:0]  DP = '0;
  logic [7:0]  LED = '0;
  logic [2:0]  BRIGHT = '0;
  logic        DISP_ON = 1'b0;
  logic        BUSY, DONE, TM_CLK, TM_STB, TM_DIO;

  tm1638_frame_seq #(.CLK_DIV(D)) dut (
    .CLK(CLK), .RST(RST), .START(START), .DIGITS(DIGITS), .DP(DP), .LED(LED),
    .BRIGHT(BRIGHT), .DISP_ON(DISP_ON), .BUSY(BUSY), .DONE(DONE),
    .TM_CLK(TM_CLK), .TM_STB(TM_STB), .TM_DIO(TM_DIO)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- bus monitor (samples on the falling edge) ----------------
  logic [7:0] mon_bytes[$];
  int         win_len[$];
  int         stb_gaps[$];
  int         busy_lens[$];
  int         done_cyc[$];
  int         cyc = 0, done_wide = 0, frag = 0;
  int         in_win = 0, nbits = 0, win_bytes = 0, have_win = 0;
  int         stb_hi_run = 0, busy_run = 0;
  logic       p_clk = 1'b1, p_stb = 1'b1, p_busy = 1'b0, p_done = 1'b0;
  logic [7:0] sh = '0;

  always @(negedge CLK) begin
    cyc++;
    if (!RST) begin
      in_win = 0; nbits = 0; win_bytes = 0; busy_run = 0; stb_hi_run = 0;
      p_clk = 1'b1; p_stb = 1'b1; p_busy = 1'b0; p_done = 1'b0;
    end else begin
      if (TM_STB) stb_hi_run++;
      if (p_stb && !TM_STB) begin
        if (have_win != 0) stb_gaps.push_back(stb_hi_run);
        stb_hi_run = 0; in_win = 1; nbits = 0; win_bytes = 0;
      end
      if (in_win != 0 && !p_clk && TM_CLK) begin
        sh = {TM_DIO, sh[7:1]};
        nbits++;
        if (nbits % 8 == 0) begin
          mon_bytes.push_back(sh);
          win_bytes++;
        end
      end
      if (!p_stb && TM_STB && in_win != 0) begin
        win_len.push_back(win_bytes);
        if (nbits % 8 != 0) frag++;
        in_win = 0; have_win = 1;
      end
      if (BUSY) busy_run++;
      else if (p_busy) begin
        busy_lens.push_back(busy_run);
        busy_run = 0;
      end
      if (DONE) begin
        done_cyc.push_back(cyc);
        if (p_done) done_wide++;
      end
      p_clk = TM_CLK; p_stb = TM_STB; p_busy = BUSY; p_done = DONE;
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] exp_q[$];

  function automatic logic [7:0] glyph_ref(input logic [3:0] n);
    case (n)
      4'h0: return 8'h3F;  4'h1: return 8'h06;  4'h2: return 8'h5B;  4'h3: return 8'h4F;
      4'h4: return 8'h66;  4'h5: return 8'h6D;  4'h6: return 8'h7D;  4'h7: return 8'h07;
      4'h8: return 8'h7F;  4'h9: return 8'h6F;  4'hA: return 8'h77;  4'hB: return 8'h7C;
      4'hC: return 8'h39;  4'hD: return 8'h5E;  4'hE: return 8'h79;  default: return 8'h00;
    endcase
  endfunction

  task automatic build_frame();
    exp_q.delete();
    exp_q.push_back(8'h40);
    exp_q.push_back(8'hC0);
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(glyph_ref(DIGITS[4*k +: 4]) | (DP[k] ? 8'h80 : 8'h00));
      exp_q.push_back(LED[k] ? 8'h01 : 8'h00);
    end
    exp_q.push_back(8'(128 + 8 * int'(DISP_ON) + int'(BRIGHT)));
  endtask

  // ---------------- helpers ----------------
  task automatic clear_mon();
    mon_bytes.delete(); win_len.delete(); stb_gaps.delete();
    busy_lens.delete(); done_cyc.delete();
    done_wide = 0; frag = 0; have_win = 0;
  endtask

  task automatic set_in(input logic [31:0] dg, input logic [7:0] dp, input logic [7:0] led,
                        input logic [2:0] br, input logic on);
    DIGITS = dg; DP = dp; LED = led; BRIGHT = br; DISP_ON = on;
  endtask

  task automatic set_rand();
    set_in($urandom, 8'($urandom), 8'($urandom), 3'($urandom_range(7)), 1'($urandom_range(1)));
  endtask

  task automatic pulse_start();
    @(negedge CLK); START = 1'b1;
    @(negedge CLK); START = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!DONE && n < 2000);
    if (!DONE) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic check_frame(input string tag, input int fb);
    if (win_len.size() < 3*fb + 3 || mon_bytes.size() < 19*fb + 19) begin
      chk({tag, "_short"}, 0, 1);
      return;
    end
    for (int w = 0; w < 3; w++)
      chk($sformatf("%s_wlen%0d", tag, w), win_len[3*fb + w], (w == 1) ? 17 : 1);
    for (int i = 0; i < 19; i++)
      chk($sformatf("%s_b%0d", tag, i), mon_bytes[19*fb + i], exp_q[i]);
  endtask

  task automatic one_frame(input string tag);
    clear_mon();
    build_frame();
    pulse_start();
    wait_done(tag);
    repeat (4) @(negedge CLK);
    chk({tag, "_nbytes"}, mon_bytes.size(), 19);
    check_frame(tag, 0);
    chk({tag, "_busy"}, (busy_lens.size() == 1) ? busy_lens[0] : -1, 310 * D);
    chk({tag, "_ndone"}, done_cyc.size(), 1);
    chk({tag, "_dwide"}, done_wide, 0);
    chk({tag, "_frag"}, frag, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;

    // Reset state, then 100 idle cycles with START low.
    repeat (3) @(negedge CLK);
    chk("rst_clk", TM_CLK, 1);
    chk("rst_stb", TM_STB, 1);
    chk("rst_dio", TM_DIO, 1);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    RST = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge CLK);
      if (TM_CLK !== 1'b1 || TM_STB !== 1'b1 || TM_DIO !== 1'b1 || BUSY !== 1'b0 || DONE !== 1'b0)
        bad++;
    end
    chk("idle_hold", bad, 0);

    // Known frame with blanked upper digits.
    set_in(32'hFFFF_1234, 8'h00, 8'h81, 3'd7, 1'b1);
    one_frame("t2");
    chk("t2_addr0", mon_bytes[2], 8'h66);
    chk("t2_addr15", mon_bytes[17], 8'h01);
    chk("t2_disp", mon_bytes[18], 8'h8F);

    // Hex glyphs, decimal point, display off.
    set_in(32'h0000_00AE, 8'h01, 8'h00, 3'd3, 1'b0);
    one_frame("t3");
    chk("t3_addr0", mon_bytes[2], 8'hF9);
    chk("t3_addr2", mon_bytes[4], 8'h77);
    chk("t3_disp", mon_bytes[18], 8'h83);

    // START held high: two back-to-back frames.
    clear_mon();
    set_rand();
    build_frame();
    @(negedge CLK); START = 1'b1;
    wait_done("t4a");
    wait_done("t4b");
    START = 1'b0;
    repeat (4) @(negedge CLK);
    chk("t4_nbytes", mon_bytes.size(), 38);
    check_frame("t4f0", 0);
    check_frame("t4f1", 1);
    chk("t4_ngaps", stb_gaps.size(), 5);
    for (int g = 0; g < 5 && g < stb_gaps.size(); g++)
      chk($sformatf("t4_gap%0d", g), stb_gaps[g], (g == 2) ? D + 1 : D);
    chk("t4_ndone", done_cyc.size(), 2);
    if (done_cyc.size() == 2) chk("t4_dspace", done_cyc[1] - done_cyc[0], 310 * D + 1);
    chk("t4_nbusy", busy_lens.size(), 2);
    for (int b = 0; b < busy_lens.size(); b++)
      chk($sformatf("t4_busy%0d", b), busy_lens[b], 310 * D);

    // Inputs changed mid-frame are ignored; START while BUSY is not queued.
    clear_mon();
    set_rand();
    build_frame();
    pulse_start();
    repeat (98) @(negedge CLK);
    DIGITS = 32'h8888_8888;
    repeat (100) @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_done("t5a");
    repeat (50) @(negedge CLK);
    chk("t5a_nbytes", mon_bytes.size(), 19);
    check_frame("t5a", 0);
    chk("t5a_nbusy", busy_lens.size(), 1);
    chk("t5a_ndone", done_cyc.size(), 1);
    one_frame("t5b");
    chk("t5b_addr0", mon_bytes[2] & 8'h7F, 8'h7F);

    // Async reset in the middle of a C1 byte, then a clean frame.
    clear_mon();
    set_rand();
    pulse_start();
    repeat (150) @(negedge CLK);
    chk("t6_pre_stb", TM_STB, 0);
    @(posedge CLK);
    #1 RST = 1'b0;
    #1;
    chk("t6_clk", TM_CLK, 1);
    chk("t6_stb", TM_STB, 1);
    chk("t6_dio", TM_DIO, 1);
    chk("t6_busy", BUSY, 0);
    chk("t6_done", DONE, 0);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    set_rand();
    one_frame("t6");

    // Randomised frames.
    for (int r = 0; r < 4; r++) begin
      set_rand();
      one_frame($sformatf("r%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
